ex_result_buf: RTL
==================

// Module: ex_result_buf
// PURPOSE
//  Execute-stage result selector and 2-entry skid buffer feeding the EX/MEM boundary.
//  Per instruction, it picks one 16-bit writeback value from ALU, bit-reverse (BTR) unit,
//  LBI, SLBI or SET, then registers it with its writeback tag.
//  It decouples execute from memory-stage stalls with a valid/ready handshake.
//  A full throughput of 1 result/cycle is sustained, and in_ready is a pure register output.
// PARAMETERS
//  N      16  datapath width (ALU, BTR, immediate, result)
//  RW      3  register-index width (8-entry register file)
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  in_valid     in   1    execute presents a completed instruction
//  in_ready     out  1    buffer can accept (registered)
//  res_sel      in   3    result source: 0 ALU, 1 BTR, 2 LBI, 3 SLBI, 4 SET, 5-7 illegal
//  alu_out      in   N    ALU result
//  btr_out      in   N    bit-reversed operand from BTR unit
//  rs_val       in   N    Rs operand (SLBI base)
//  imm          in   N    immediate, already sign/zero-extended by decode
//  set_flag     in   1    SEQ/SLT/SLE/SCO condition outcome
//  wr_reg       in   RW   destination register index
//  wr_en        in   1    instruction writes the register file
//  flush        in   1    squash all buffered and incoming results (branch redirect)
//  out_valid    out  1    result available to memory stage
//  out_ready    in   1    memory stage consumes result
//  out_result   out  N    selected result
//  out_wr_reg   out  RW   destination index
//  out_wr_en    out  1    writeback enable (forced 0 for illegal res_sel)
//  out_illegal  out  1    entry was captured with res_sel 5-7
// BEHAVIOUR
//  Reset: all storage and outputs are cleared; in_ready=1; out_valid=0; out_result=0;
//   out_wr_reg=0; out_wr_en=0; out_illegal=0.
//  Select (combinational, before capture):
//   ALU -> alu_out; BTR -> btr_out; LBI -> imm; SLBI -> {rs_val[7:0], imm[7:0]};
//   SET -> {15'b0, set_flag}; illegal -> 0 with wr_en cleared and illegal=1.
//  Storage: a main entry M drives the outputs, and a skid entry S has a valid bit each.
//   out_valid = M.v. in_ready = !S.v.
//  Per cycle (acc = in_valid & in_ready, pop = out_valid & out_ready):
//   flush=1    -> M.v=0 and S.v=0 next cycle, whatever acc/pop is. The incoming beat is dropped.
//   !M.v & acc -> capture into M. Latency is 1 cycle from accept to out_valid.
//   M.v & pop & !S.v & acc   -> capture into M (back-to-back, 1/cycle).
//   M.v & pop & !S.v & !acc  -> M.v=0.
//   M.v & !pop & acc         -> capture into S (S empty guaranteed by in_ready).
//   M.v & pop & S.v          -> M<=S, S.v=0 (no accept possible this cycle).
//  Ordering: strict FIFO. No result is duplicated or lost except through flush.
//  Payload of an entry is stable while out_valid & !out_ready.
//  Reset asserted mid-transfer: both entries are invalidated immediately (asynchronous).
// STRUCTURE
//  A shared package holds the res_sel localparams (RES_ALU..RES_SET) and the
//  N/RW defaults used by decode and the execute stage.
//  One sub-module, result_mux: combinational select plus illegal/wr_en qualification.
//  This module holds the skid FSM (states EMPTY, ONE, TWO) and the entry registers.
// TESTING
//  1. res_sel=1, btr_out=16'h0001, out_ready=1 -> next cycle out_valid=1, out_result=16'h0001.
//  2. res_sel=3, rs_val=16'h12AB, imm=16'h00CD -> out_result=16'hABCD; res_sel=4,
//     set_flag=1 -> 16'h0001.
//  3. out_ready=0, push A then B -> in_ready=0 after B. Raise out_ready -> A then B in order.
//     No bubble between them.
//  4. Buffer full, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1.
//     The incoming beat never appears.
//  5. res_sel=6, wr_en=1 -> out_illegal=1, out_wr_en=0, out_result=0.
//  6. Buffer full, then rst_n low asynchronously -> out_valid=0 and in_ready=1 with no
//     clock edge. Normal operation resumes after release.

Source files
------------

// File: rtl/ex_result_buf_pkg.sv
// Shared execute-stage constants: result-source encodings and datapath defaults.
package ex_result_buf_pkg;
  localparam int N_DEF  = 16;
  localparam int RW_DEF = 3;

  localparam logic [2:0] RES_ALU  = 3'd0;
  localparam logic [2:0] RES_BTR  = 3'd1;
  localparam logic [2:0] RES_LBI  = 3'd2;
  localparam logic [2:0] RES_SLBI = 3'd3;
  localparam logic [2:0] RES_SET  = 3'd4;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel <= RES_SET;
  endfunction
endpackage

// File: rtl/ex_result_buf_result_mux.sv
// Writeback value select; illegal sources produce zero and never write the register file.
module result_mux
  import ex_result_buf_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [2:0]   res_sel_i,
  input  logic [N-1:0] alu_out_i,
  input  logic [N-1:0] btr_out_i,
  input  logic [N-1:0] rs_val_i,
  input  logic [N-1:0] imm_i,
  input  logic         set_flag_i,
  input  logic         wr_en_i,
  output logic [N-1:0] result_o,
  output logic         wr_en_o,
  output logic         illegal_o
);
  always_comb begin
    result_o  = '0;
    illegal_o = ~sel_legal(res_sel_i);
    wr_en_o   = wr_en_i & ~illegal_o;
    case (res_sel_i)
      RES_ALU:  result_o = alu_out_i;
      RES_BTR:  result_o = btr_out_i;
      RES_LBI:  result_o = imm_i;
      RES_SLBI: result_o = {rs_val_i[N-9:0], imm_i[7:0]};
      RES_SET:  result_o = {{(N-1){1'b0}}, set_flag_i};
      default:  result_o = '0;
    endcase
  end
endmodule

// File: rtl/ex_result_buf.sv
// Execute result select plus 2-entry skid buffer toward the EX/MEM boundary.
module ex_result_buf
  import ex_result_buf_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    res_sel,
  input  logic [N-1:0]  alu_out,
  input  logic [N-1:0]  btr_out,
  input  logic [N-1:0]  rs_val,
  input  logic [N-1:0]  imm,
  input  logic          set_flag,
  input  logic [RW-1:0] wr_reg,
  input  logic          wr_en,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [RW-1:0] out_wr_reg,
  output logic          out_wr_en,
  output logic          out_illegal
);
  // Encoding chosen so bit0 is M.v and bit1 is S.v: both handshake outputs are flop bits.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;
  localparam int EW = N + RW + 2;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] m_q, m_d, s_q, s_d, in_ent;
  logic [N-1:0]  mux_result;
  logic          mux_wr_en, mux_illegal;
  logic          acc, pop;

  result_mux #(.N(N)) u_mux (
    .res_sel_i  (res_sel),
    .alu_out_i  (alu_out),
    .btr_out_i  (btr_out),
    .rs_val_i   (rs_val),
    .imm_i      (imm),
    .set_flag_i (set_flag),
    .wr_en_i    (wr_en),
    .result_o   (mux_result),
    .wr_en_o    (mux_wr_en),
    .illegal_o  (mux_illegal)
  );

  assign in_ent    = {mux_result, wr_reg, mux_wr_en, mux_illegal};
  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin state_d = ST_ONE; m_d = in_ent; end
        ST_ONE: begin
          if (pop && acc)   m_d = in_ent;
          else if (pop)     state_d = ST_EMPTY;
          else if (acc)     begin state_d = ST_TWO; s_d = in_ent; end
        end
        ST_TWO:   if (pop) begin state_d = ST_ONE; m_d = s_q; end
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign out_result  = m_q[EW-1 -: N];
  assign out_wr_reg  = m_q[RW+1:2];
  assign out_wr_en   = m_q[1];
  assign out_illegal = m_q[0];
endmodule
